// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_arbiter_fifo.sv
// Small synchronous FIFO with first-word-fall-through head.
// Depth is 2**SIZE entries of DBITS bits; pop of an empty FIFO and push
// into a full FIFO are ignored.
module fifo #(
  parameter int DBITS = 2,
  parameter int SIZE  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [DBITS-1:0] i_data,
  input  logic             i_pop,
  output logic [DBITS-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  logic [DBITS-1:0] r_mem [0:(1<<SIZE)-1];
  logic [SIZE:0]    r_wptr;
  logic [SIZE:0]    r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & ~o_full;

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage array; contents need no reset since the pointers gate validity.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr[SIZE-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rptr[SIZE-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[SIZE] != r_rptr[SIZE]) &&
                   (r_wptr[SIZE-1:0] == r_rptr[SIZE-1:0]);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NREQ Avalon-MM requesters onto one pipelined Avalon-MM master.
// One command in flight on the master bus at a time; read returns are routed
// back in issue order via a tag FIFO of requester indices.
// Optional macro MEM_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of the default round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ            = 3,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NREQ-1:0][ADDR_W-1:0]  s_address,
  input  logic [NREQ-1:0][DATA_W-1:0]  s_writedata,
  input  logic [NREQ-1:0][BE_W-1:0]    s_byteenable,
  input  logic [NREQ-1:0]              s_read,
  input  logic [NREQ-1:0]              s_write,
  output logic [NREQ-1:0]              s_waitrequest,
  output logic [NREQ-1:0]              s_readdatavalid,
  output logic [DATA_W-1:0]            s_readdata,
  output logic [ADDR_W-1:0]            master_address,
  output logic                         master_read,
  output logic                         master_write,
  output logic [BE_W-1:0]              master_byteenable,
  output logic [DATA_W-1:0]            master_writedata,
  input  logic [DATA_W-1:0]            master_readdata,
  input  logic                         master_readdatavalid,
  input  logic                         master_waitrequest,
  output logic                         rd_underflow
);

  localparam int GW = $clog2(NREQ);
  localparam int SW = $clog2(MAX_OUTSTANDING);
  localparam int OW = SW + 1;
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

  state_t            r_state, w_state_nxt;
  logic [GW-1:0]     r_grant, w_grant_nxt;
  logic [ADDR_W-1:0] r_master_address, w_address_nxt;
  logic [DATA_W-1:0] r_master_writedata, w_writedata_nxt;
  logic [BE_W-1:0]   r_master_byteenable, w_byteenable_nxt;
  logic              r_master_read, w_read_nxt;
  logic              r_master_write, w_write_nxt;
  logic [OW-1:0]     r_outstanding;
  logic              r_rd_underflow;

  logic [NREQ-1:0]   w_elig;
  logic              w_any;
  logic [GW-1:0]     w_win;
  logic              w_accept;
  logic              w_rd_accept;
  logic              w_rdv_pop;
  logic [GW-1:0]     w_tag;
  logic              w_fifo_empty;
  logic              w_fifo_full;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [GW-1:0]     r_last_grant, w_last_grant_nxt;
  int                w_rr_idx;
`endif

  // Writes are always eligible; reads only while return slots remain.
  assign w_elig      = s_write | (s_read & {NREQ{r_outstanding < MAX_CNT}});
  assign w_accept    = (r_state == S_BUSY) & ~master_waitrequest;
  assign w_rd_accept = w_accept & r_master_read;
  assign w_rdv_pop   = master_readdatavalid & ~w_fifo_empty;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downwards so the lowest eligible index wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_any = 1'b1;
        w_win = GW'(i);
      end else begin
        w_any = w_any;
      end
    end
  end
`else
  // Round-robin: scan offsets from far to near so the first eligible port
  // after last_grant (wrapping) is the final survivor.
  always_comb begin
    w_any    = 1'b0;
    w_win    = '0;
    w_rr_idx = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_rr_idx = int'(r_last_grant) + k;
      if (w_rr_idx >= NREQ) w_rr_idx = w_rr_idx - NREQ;
      else                  w_rr_idx = w_rr_idx;
      if (w_elig[w_rr_idx]) begin
        w_any = 1'b1;
        w_win = GW'(w_rr_idx);
      end else begin
        w_any = w_any;
      end
    end
  end
`endif

  // Next-state and next master command: latch winner in IDLE, hold in BUSY
  // until the slave stops waitrequesting.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_address_nxt    = r_master_address;
    w_writedata_nxt  = r_master_writedata;
    w_byteenable_nxt = r_master_byteenable;
    w_read_nxt       = r_master_read;
    w_write_nxt      = r_master_write;
`ifndef MEM_ARB_FIXED_PRIO_EN
    w_last_grant_nxt = r_last_grant;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt      = S_BUSY;
          w_grant_nxt      = w_win;
          w_address_nxt    = s_address[w_win];
          w_writedata_nxt  = s_writedata[w_win];
          w_byteenable_nxt = s_byteenable[w_win];
          w_write_nxt      = s_write[w_win];
          w_read_nxt       = ~s_write[w_win];
`ifndef MEM_ARB_FIXED_PRIO_EN
          w_last_grant_nxt = w_win;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (!master_waitrequest) begin
          w_state_nxt = S_IDLE;
          w_read_nxt  = 1'b0;
          w_write_nxt = 1'b0;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
      end
    endcase
  end

  // State and master command registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state             <= S_IDLE;
      r_grant             <= '0;
      r_master_address    <= '0;
      r_master_writedata  <= '0;
      r_master_byteenable <= 4'b1111;
      r_master_read       <= 1'b0;
      r_master_write      <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_last_grant        <= GW'(NREQ - 1);
`endif
    end else begin
      r_state             <= w_state_nxt;
      r_grant             <= w_grant_nxt;
      r_master_address    <= w_address_nxt;
      r_master_writedata  <= w_writedata_nxt;
      r_master_byteenable <= w_byteenable_nxt;
      r_master_read       <= w_read_nxt;
      r_master_write      <= w_write_nxt;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_last_grant        <= w_last_grant_nxt;
`endif
    end
  end

  // Outstanding-read count and sticky underflow flag for orphan returns.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_outstanding  <= '0;
      r_rd_underflow <= 1'b0;
    end else begin
      case ({w_rd_accept, w_rdv_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      r_rd_underflow <= r_rd_underflow | (master_readdatavalid & w_fifo_empty);
    end
  end

  fifo #(
    .DBITS (GW),
    .SIZE  (SW)
  ) u_tag_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_rd_accept),
    .i_data  (r_grant),
    .i_pop   (w_rdv_pop),
    .o_data  (w_tag),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  // Requester handshakes: release only the granted port on acceptance, and
  // steer a read return to the requester at the head of the tag FIFO.
  always_comb begin
    s_waitrequest   = '1;
    s_readdatavalid = '0;
    if (w_accept) s_waitrequest[r_grant] = 1'b0;
    else          s_waitrequest = '1;
    if (w_rdv_pop) s_readdatavalid[w_tag] = 1'b1;
    else           s_readdatavalid = '0;
  end

  assign s_readdata        = master_readdata;
  assign master_address    = r_master_address;
  assign master_read       = r_master_read;
  assign master_write      = r_master_write;
  assign master_byteenable = r_master_byteenable;
  assign master_writedata  = r_master_writedata;
  assign rd_underflow      = r_rd_underflow;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected master commands
// and expected read returns; a negedge monitor pops and compares them.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int MAXO = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [NREQ-1:0][ADDR_W-1:0] s_address;
  logic [NREQ-1:0][DATA_W-1:0] s_writedata;
  logic [NREQ-1:0][BE_W-1:0]   s_byteenable;
  logic [NREQ-1:0]             s_read;
  logic [NREQ-1:0]             s_write;
  logic [NREQ-1:0]             s_waitrequest;
  logic [NREQ-1:0]             s_readdatavalid;
  logic [DATA_W-1:0]           s_readdata;
  logic [ADDR_W-1:0]           master_address;
  logic                        master_read;
  logic                        master_write;
  logic [BE_W-1:0]             master_byteenable;
  logic [DATA_W-1:0]           master_writedata;
  logic [DATA_W-1:0]           master_readdata;
  logic                        master_readdatavalid;
  logic                        master_waitrequest;
  logic                        rd_underflow;

  mem_arbiter #(.NREQ(NREQ), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_read(s_read), .s_write(s_write),
    .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid),
    .s_readdata(s_readdata),
    .master_address(master_address), .master_read(master_read),
    .master_write(master_write), .master_byteenable(master_byteenable),
    .master_writedata(master_writedata), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest), .rd_underflow(rd_underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          port;
    bit          wr;
    logic [25:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } cmd_t;

  typedef struct {
    int          port;
    logic [31:0] data;
  } ret_t;

  cmd_t exp_cmd[$];
  ret_t exp_ret[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   seq[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each accepted master command and each read return.
  always @(negedge clock) begin
    int   g;
    cmd_t c;
    ret_t r;
    if (reset) begin
      if ((master_read || master_write) && !master_waitrequest) begin
        g = -1;
        for (int i = 0; i < NREQ; i++) if (!s_waitrequest[i]) g = i;
        n_acc++;
        check("cmd_expected", 64'(exp_cmd.size() != 0), 64'd1);
        if (exp_cmd.size() != 0) begin
          c = exp_cmd.pop_front();
          check("cmd_port", 64'(g), 64'(c.port));
          check("cmd_kind", 64'({master_write, master_read}), c.wr ? 64'd2 : 64'd1);
          check("cmd_addr", 64'(master_address), 64'(c.addr));
          check("cmd_be", 64'(master_byteenable), 64'(c.be));
          if (c.wr) check("cmd_wdata", 64'(master_writedata), 64'(c.data));
        end
      end
      if (s_readdatavalid != '0) begin
        check("ret_expected", 64'(exp_ret.size() != 0), 64'd1);
        if (exp_ret.size() != 0) begin
          r = exp_ret.pop_front();
          check("ret_port", 64'(s_readdatavalid), 64'(1 << r.port));
          check("ret_data", 64'(s_readdata), 64'(r.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_cmd(input int p, input bit wr, input logic [25:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    cmd_t c;
    c.port = p; c.wr = wr; c.addr = a; c.data = d; c.be = be;
    exp_cmd.push_back(c);
  endtask

  task automatic push_ret(input int p, input logic [31:0] d);
    ret_t r;
    r.port = p; r.data = d;
    exp_ret.push_back(r);
  endtask

  task automatic set_cmd(input int p, input bit rd, input bit wr, input logic [25:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    s_read[p] = rd; s_write[p] = wr; s_address[p] = a;
    s_writedata[p] = d; s_byteenable[p] = be;
  endtask

  task automatic clr(input int p);
    s_read[p] = 1'b0;
    s_write[p] = 1'b0;
  endtask

  task automatic do_reset();
    check("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
    check("ret_queue_drained", 64'(exp_ret.size()), 64'd0);
    reset = 1'b0;
    s_read = '0; s_write = '0; s_address = '0; s_writedata = '0; s_byteenable = '0;
    master_readdata = '0; master_readdatavalid = 1'b0; master_waitrequest = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int k;
    k = 0;
    while (n_acc < target && k < budget) begin
      tick();
      k++;
    end
    check("accept_in_time", 64'(n_acc >= target), 64'd1);
  endtask

  task automatic ret(input logic [31:0] d);
    master_readdatavalid = 1'b1;
    master_readdata = d;
    tick();
    master_readdatavalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
`ifdef MEM_ARB_FIXED_PRIO_EN
    seq = '{0, 0, 0, 0, 0, 0};
`else
    seq = '{0, 1, 2, 0, 1, 2};
`endif
    do_reset();

    // Reset state
    check("rst_mread", 64'(master_read), 64'd0);
    check("rst_mwrite", 64'(master_write), 64'd0);
    check("rst_maddr", 64'(master_address), 64'd0);
    check("rst_mwdata", 64'(master_writedata), 64'd0);
    check("rst_mbe", 64'(master_byteenable), 64'hF);
    check("rst_underflow", 64'(rd_underflow), 64'd0);
    check("rst_swait", 64'(s_waitrequest), 64'h7);

    // Single write from port 0: on the bus one cycle later, one-cycle release
    set_cmd(0, 1'b0, 1'b1, 26'd100, 32'hDEADBEEF, 4'hF);
    push_cmd(0, 1'b1, 26'd100, 32'hDEADBEEF, 4'hF);
    tick();
    check("wr0_mwrite", 64'(master_write), 64'd1);
    check("wr0_maddr", 64'(master_address), 64'd100);
    check("wr0_swait_low", 64'(s_waitrequest), 64'h6);
    tick();
    clr(0);
    check("wr0_after_swait", 64'(s_waitrequest), 64'h7);
    check("wr0_after_mwrite", 64'(master_write), 64'd0);
    tick();
    check("wr0_once_swait", 64'(s_waitrequest), 64'h7);
    check("wr0_once_mwrite", 64'(master_write), 64'd0);

    // All ports writing continuously from reset
    do_reset();
    for (int k = 0; k < 6; k++)
      push_cmd(seq[k], 1'b1, 26'(16 + seq[k]), 32'(160 + seq[k]), 4'hF);
    for (int p = 0; p < NREQ; p++)
      set_cmd(p, 1'b0, 1'b1, 26'(16 + p), 32'(160 + p), 4'hF);
    base = n_acc;
    wait_acc(base + 6, 40);
    for (int p = 0; p < NREQ; p++) clr(p);
    tick();
    tick();
    check("arb_no_extra", 64'(n_acc), 64'(base + 6));

    // Two reads, returns routed in issue order
    do_reset();
    set_cmd(1, 1'b1, 1'b0, 26'd8, 32'd0, 4'hF);
    push_cmd(1, 1'b0, 26'd8, 32'd0, 4'hF);
    push_ret(1, 32'h11);
    wait_acc(n_acc + 1, 20);
    clr(1);
    set_cmd(0, 1'b1, 1'b0, 26'd12, 32'd0, 4'hF);
    push_cmd(0, 1'b0, 26'd12, 32'd0, 4'hF);
    push_ret(0, 32'h22);
    wait_acc(n_acc + 1, 20);
    clr(0);
    ret(32'h11);
    ret(32'h22);
    tick();
    check("ret_no_underflow", 64'(rd_underflow), 64'd0);

    // Outstanding limit: reads blocked, writes still granted
    do_reset();
    for (int k = 0; k < MAXO; k++) begin
      set_cmd(k % 3, 1'b1, 1'b0, 26'(64 + k), 32'd0, 4'hF);
      push_cmd(k % 3, 1'b0, 26'(64 + k), 32'd0, 4'hF);
      push_ret(k % 3, 32'(256 + k));
      wait_acc(n_acc + 1, 20);
      clr(k % 3);
    end
    set_cmd(2, 1'b1, 1'b0, 26'h80, 32'd0, 4'hF);
    set_cmd(0, 1'b0, 1'b1, 26'h90, 32'hCAFEF00D, 4'hF);
    push_cmd(0, 1'b1, 26'h90, 32'hCAFEF00D, 4'hF);
    wait_acc(n_acc + 1, 20);
    clr(0);
    base = n_acc;
    repeat (4) tick();
    check("full_read_held", 64'(n_acc), 64'(base));
    check("full_read_swait", 64'(s_waitrequest[2]), 64'd1);
    push_cmd(2, 1'b0, 26'h80, 32'd0, 4'hF);
    push_ret(2, 32'h200);
    ret(32'd256);
    wait_acc(base + 1, 20);
    clr(2);
    for (int k = 1; k < MAXO; k++) ret(32'(256 + k));
    ret(32'h200);
    tick();

    // Slave waitrequest stall: command held stable, requesters all stalled
    do_reset();
    master_waitrequest = 1'b1;
    set_cmd(1, 1'b0, 1'b1, 26'h55, 32'h1234, 4'b0011);
    push_cmd(1, 1'b1, 26'h55, 32'h1234, 4'b0011);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_cmd", {master_write, master_read, 4'(master_byteenable),
                          26'(master_address), 32'(master_writedata)},
            {1'b1, 1'b0, 4'b0011, 26'h55, 32'h1234});
      check("stall_swait", 64'(s_waitrequest), 64'h7);
      tick();
    end
    master_waitrequest = 1'b0;
    wait_acc(n_acc + 1, 10);
    clr(1);

    // Orphan return sets sticky underflow until reset
    check("uf_before", 64'(rd_underflow), 64'd0);
    ret(32'hBAD);
    check("uf_set", 64'(rd_underflow), 64'd1);
    repeat (3) tick();
    check("uf_sticky", 64'(rd_underflow), 64'd1);
    do_reset();
    check("uf_cleared", 64'(rd_underflow), 64'd0);

    // Read issued before reset, returned after: underflow, no routing
    set_cmd(2, 1'b1, 1'b0, 26'h33, 32'd0, 4'hF);
    push_cmd(2, 1'b0, 26'h33, 32'd0, 4'hF);
    wait_acc(n_acc + 1, 20);
    clr(2);
    do_reset();
    ret(32'h77);
    check("uf_prereset_read", 64'(rd_underflow), 64'd1);

    // Reset while a stalled command is on the bus abandons it
    do_reset();
    master_waitrequest = 1'b1;
    set_cmd(0, 1'b0, 1'b1, 26'h44, 32'h4444, 4'hF);
    tick();
    check("abandon_pending", 64'(master_write), 64'd1);
    do_reset();
    check("abandon_mwrite", 64'(master_write), 64'd0);
    base = n_acc;
    repeat (3) tick();
    check("abandon_no_accept", 64'(n_acc), 64'(base));

    check("final_cmd_queue", 64'(exp_cmd.size()), 64'd0);
    check("final_ret_queue", 64'(exp_ret.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requester ports (port 0 ztest, 1 rasterizer fetch, 2 clear engine).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 8, power of two, maximum reads issued but not yet returned.
REQ-003 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports s_address / s_writedata / s_byteenable  input  [NREQ][26] / [NREQ][32] / [NREQ][4]  per-requester command fields.
REQ-006 SHALL have ports s_read / s_write  input  [NREQ]  per-requester command strobes.
REQ-007 SHALL have ports s_waitrequest  output  [NREQ]  and s_readdatavalid  output  [NREQ]  per-requester handshakes.
REQ-008 SHALL have port s_readdata  output  32  read data broadcast to all requesters, qualified by s_readdatavalid.
REQ-009 SHALL have ports master_address 26, master_read 1, master_write 1, master_byteenable 4, master_writedata 32 (outputs) and master_readdata 32, master_readdatavalid 1, master_waitrequest 1 (inputs)  pipelined Avalon-MM master.
REQ-010 SHALL have port rd_underflow  output  1  sticky: readdatavalid arrived with no read outstanding.

Function
REQ-011 SHALL implement states S_IDLE and S_BUSY.
REQ-012 In S_IDLE, port i is eligible when s_write[i], or s_read[i] with outstanding < MAX_OUTSTANDING.
REQ-013 In S_IDLE with any eligible port, SHALL register the winner's command onto master_* at the next edge, record grant index, and enter S_BUSY; a command visible at edge t is on the master bus after t+1.
REQ-014 Default arbitration SHALL be round-robin: search starts at last_grant+1 modulo NREQ; last_grant updates on each grant.
REQ-015 In S_BUSY, master_* SHALL hold stable while master_waitrequest=1.
REQ-016 s_waitrequest[i] SHALL be 0 only in the cycle state=S_BUSY, grant=i, master_waitrequest=0; it is 1 otherwise, including in S_IDLE.
REQ-017 On acceptance (S_BUSY, master_waitrequest=0) SHALL deassert master_read/master_write at the next edge and return to S_IDLE; peak throughput one command per 2 cycles.
REQ-018 On read acceptance SHALL push grant index into the tag FIFO and increment outstanding.
REQ-019 On master_readdatavalid SHALL drive s_readdata=master_readdata and assert s_readdatavalid[head tag] combinationally in the same cycle, pop the tag, and decrement outstanding.
REQ-020 Read acceptance and readdatavalid in the same cycle SHALL leave outstanding unchanged.
REQ-021 readdatavalid with an empty tag FIFO SHALL set rd_underflow, with no s_readdatavalid asserted.
REQ-022 With both s_read[i] and s_write[i] asserted, the write SHALL be issued and the read ignored.
REQ-023 At outstanding = MAX_OUTSTANDING, reads SHALL be ineligible and writes SHALL still be granted.
REQ-024 Return data SHALL arrive in issue order; no reordering.

Reset
REQ-025 With reset=0 at an edge: state=S_IDLE, last_grant=NREQ-1, outstanding=0, tag FIFO empty, master_read=master_write=0, master_address=0, master_writedata=0, master_byteenable=4'b1111, rd_underflow=0.
REQ-026 Reset mid-transaction SHALL abandon the command; readdatavalid for pre-reset reads after reset SHALL set rd_underflow.

Configuration
REQ-027 With macro MEM_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority, lowest eligible index wins, and last_grant is unused. Without it, round-robin per REQ-014.

Structure
REQ-028 Package mem_arb_pkg SHALL hold state_t (S_IDLE, S_BUSY) and constants ADDR_W=26, DATA_W=32, BE_W=4.
REQ-029 The tag FIFO SHALL be one instance of the existing fifo module, DBITS=$clog2(NREQ), SIZE=$clog2(MAX_OUTSTANDING).

Verification
REQ-030 Port 0 write addr 100, data 0xDEADBEEF, waitrequest=0 -> master_write=1, address 100 one cycle later; s_waitrequest[0]=0 for exactly 1 cycle.
REQ-031 Ports 0,1,2 write continuously from reset -> grants 0,1,2,0,1,2. With MEM_ARB_FIXED_PRIO_EN -> grants 0,0,0.
REQ-032 Port 1 reads addr 8, then port 0 reads addr 12; memory returns 0x11, then 0x22 -> s_readdatavalid[1] with 0x11, then s_readdatavalid[0] with 0x22.
REQ-033 8 reads unreturned, then port 2 read plus port 0 write -> write granted, read held until first readdatavalid.
REQ-034 master_waitrequest held 5 cycles -> master_* stable, s_waitrequest high throughout; readdatavalid with nothing outstanding -> rd_underflow=1 until reset.
